// File: rtl/game_pkg.sv
// Shared state codes, parameter defaults and BCD limits for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    MISS  = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam int DEF_LIVES          = 3;
  localparam int DEF_SERVE_FRAMES   = 60;
  localparam int DEF_MISS_FRAMES    = 90;
  localparam int DEF_HITS_PER_LEVEL = 3;
  localparam int DEF_MAX_LEVEL      = 3;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of wrapping.
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  carry;

  // Saturation gates the whole ripple so 9999 never rolls to 0000.
  assign carry[0] = inc_i && (cnt_q != BCD_MAX);

  for (genvar g = 0; g < 4; g++) begin : g_dig
    logic [3:0] dig;
    logic       nine;
    assign dig  = cnt_q[4*g +: 4];
    assign nine = (dig == 4'd9);
    assign cnt_d[4*g +: 4] = carry[g] ? (nine ? 4'd0 : dig + 4'd1) : dig;
    if (g < 3) begin : g_c
      assign carry[g+1] = carry[g] && nine;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// Frame-paced game sequencer: serve/play/pause/miss/over, lives, level and BCD score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES    = DEF_MISS_FRAMES,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  output logic        ball_hold,
  output logic        ball_reset,
  output logic        paddle_en,
  output logic [2:0]  speed,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam int FMAX = max_i(SERVE_FRAMES, MISS_FRAMES);
  localparam int FCW  = $clog2(FMAX + 1);
  localparam int HCW  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  state_e         state_q, state_d;
  logic           start_q, start_edge;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [HCW-1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0]     level_q, level_d;
  logic [1:0]     lives_q, lives_d;
  logic           ball_hold_q, ball_reset_q, paddle_en_q, game_over_q;
  logic [2:0]     speed_q;
  logic           new_game, enter_serve, score_inc;

  assign start_edge = start && !start_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    level_d     = level_q;
    lives_d     = lives_q;
    new_game    = 1'b0;
    enter_serve = 1'b0;
    score_inc   = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) new_game = 1'b1;
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q <= FCW'(1)) state_d = PLAY;
          else                        frame_cnt_d = frame_cnt_q - FCW'(1);
        end
      end
      PLAY: begin
        // miss beats hit beats start; a coincident hit is dropped
        if (miss) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = OVER;
          end else begin
            state_d     = MISS;
            frame_cnt_d = FCW'(MISS_FRAMES);
          end
        end else if (hit) begin
          score_inc = 1'b1;
          if (hit_cnt_q == HCW'(HITS_PER_LEVEL - 1)) begin
            hit_cnt_d = '0;
            if (level_q < 2'(MAX_LEVEL)) level_d = level_q + 2'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + HCW'(1);
          end
        end else if (start_edge) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_edge) state_d = PLAY;
      end
      MISS: begin
        if (frame_tick) begin
          if (frame_cnt_q <= FCW'(1)) begin
            enter_serve = 1'b1;
            level_d     = '0;
            hit_cnt_d   = '0;
          end else begin
            frame_cnt_d = frame_cnt_q - FCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_game) begin
      enter_serve = 1'b1;
      lives_d     = 2'(LIVES);
      level_d     = '0;
      hit_cnt_d   = '0;
    end
    if (enter_serve) begin
      state_d     = SERVE;
      frame_cnt_d = FCW'(SERVE_FRAMES);
    end
  end

  // Outputs are derived from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      frame_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      level_q      <= '0;
      lives_q      <= 2'(LIVES);
      ball_hold_q  <= 1'b1;
      ball_reset_q <= 1'b0;
      paddle_en_q  <= 1'b0;
      game_over_q  <= 1'b0;
      speed_q      <= 3'd1;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      frame_cnt_q  <= frame_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      ball_hold_q  <= (state_d != PLAY);
      ball_reset_q <= enter_serve;
      paddle_en_q  <= (state_d == SERVE) || (state_d == PLAY);
      game_over_q  <= (state_d == OVER);
      speed_q      <= {1'b0, level_d} + 3'd1;
    end
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (new_game),
    .inc_i   (score_inc),
    .count_o (score)
  );

  assign ball_hold  = ball_hold_q;
  assign ball_reset = ball_reset_q;
  assign paddle_en  = paddle_en_q;
  assign speed      = speed_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: behavioural game model compared every cycle, plus directed scenarios.
module tb_game_ctrl;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        frame_tick = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic        ball_hold, ball_reset, paddle_en, game_over;
  logic [2:0]  speed, state;
  logic [1:0]  level, lives;
  logic [15:0] score;

  int n_pass = 0, n_tot = 0;

  game_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .hit(hit), .miss(miss), .ball_hold(ball_hold), .ball_reset(ball_reset),
    .paddle_en(paddle_en), .speed(speed), .level(level), .lives(lives),
    .score(score), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Codes: 0 idle, 1 serve, 2 play, 3 pause, 4 miss, 5 over.
  int m_state = 0, m_lives = 3, m_score = 0, m_lvl_hits = 0, m_ticks = 0;
  bit m_sq = 0, m_br = 0;

  function automatic int m_level();
    return (m_lvl_hits / 3 > 3) ? 3 : m_lvl_hits / 3;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic m_enter_serve();
    m_state = 1; m_ticks = 0; m_br = 1;
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 3; m_score = 0; m_lvl_hits = 0; m_ticks = 0; m_sq = 0; m_br = 0;
  endtask

  task automatic model_step();
    bit e;
    e = start && !m_sq;
    m_sq = start;
    m_br = 0;
    case (m_state)
      0, 5: if (e) begin m_lives = 3; m_score = 0; m_lvl_hits = 0; m_enter_serve(); end
      1: if (frame_tick) begin m_ticks++; if (m_ticks == 60) m_state = 2; end
      2: begin
        if (miss) begin
          m_lives--; m_ticks = 0;
          m_state = (m_lives == 0) ? 5 : 4;
        end else if (hit) begin
          m_score = (m_score >= 9999) ? 9999 : m_score + 1;
          m_lvl_hits++;
        end else if (e) m_state = 3;
      end
      3: if (e) m_state = 2;
      4: if (frame_tick) begin
           m_ticks++;
           if (m_ticks == 90) begin m_lvl_hits = 0; m_enter_serve(); end
         end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("state",      int'(state),      m_state);
    chk("ball_hold",  int'(ball_hold),  int'(m_state != 2));
    chk("ball_reset", int'(ball_reset), int'(m_br));
    chk("paddle_en",  int'(paddle_en),  int'(m_state == 1 || m_state == 2));
    chk("speed",      int'(speed),      m_level() + 1);
    chk("level",      int'(level),      m_level());
    chk("lives",      int'(lives),      m_lives);
    chk("score",      int'(score),      to_bcd(m_score));
    chk("game_over",  int'(game_over),  int'(m_state == 5));
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit t, input bit h, input bit m, input bit s);
    frame_tick = t; hit = h; miss = m; start = s;
    @(negedge clk);
    frame_tick = 0; hit = 0; miss = 0; start = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(1, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".hold"},  int'(ball_hold), 1);
    chk({tag, ".brst"},  int'(ball_reset), 0);
    chk({tag, ".pad"},   int'(paddle_en), 0);
    chk({tag, ".speed"}, int'(speed), 1);
    chk({tag, ".level"}, int'(level), 0);
    chk({tag, ".lives"}, int'(lives), 3);
    chk({tag, ".score"}, int'(score), 0);
    chk({tag, ".gover"}, int'(game_over), 0);
  endtask

  initial begin
    idle(3);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    idle(1);

    pulse(0, 0, 0, 1);
    chk("new.state", int'(state), 1);
    chk("new.brst",  int'(ball_reset), 1);
    chk("new.lives", int'(lives), 3);
    chk("new.score", int'(score), 0);
    idle(1);
    chk("new.brst_off", int'(ball_reset), 0);
    ticks(59);
    chk("serve59.state", int'(state), 1);
    ticks(1);
    chk("serve60.state", int'(state), 2);
    chk("serve60.hold",  int'(ball_hold), 0);

    repeat (7) pulse(0, 1, 0, 0);
    chk("hit7.score", int'(score), 16'h0007);
    chk("hit7.level", int'(level), 2);
    chk("hit7.speed", int'(speed), 3);
    repeat (5) pulse(0, 1, 0, 0);
    chk("hit12.score", int'(score), 16'h0012);
    chk("hit12.level", int'(level), 3);
    chk("hit12.speed", int'(speed), 4);

    pulse(0, 1, 1, 0);
    chk("hm.score", int'(score), 16'h0012);
    chk("hm.lives", int'(lives), 2);
    chk("hm.state", int'(state), 4);
    ticks(89);
    chk("miss89.state", int'(state), 4);
    ticks(1);
    chk("miss90.state", int'(state), 1);
    chk("miss90.brst",  int'(ball_reset), 1);
    chk("miss90.level", int'(level), 0);
    chk("miss90.lives", int'(lives), 2);
    idle(1);

    ticks(60);
    pulse(0, 0, 1, 0);
    chk("m2.lives", int'(lives), 1);
    ticks(90);
    ticks(60);
    pulse(0, 0, 1, 0);
    chk("m3.lives", int'(lives), 0);
    chk("m3.state", int'(state), 5);
    chk("m3.gover", int'(game_over), 1);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    chk("over.score", int'(score), 16'h0012);
    pulse(0, 0, 0, 1);
    chk("restart.state", int'(state), 1);
    chk("restart.lives", int'(lives), 3);
    chk("restart.score", int'(score), 0);
    ticks(60);

    // pause press held for 10 cycles, with hits and ticks landing meanwhile
    start = 1;
    @(negedge clk);
    chk("pause.state", int'(state), 3);
    chk("pause.hold",  int'(ball_hold), 1);
    chk("pause.pad",   int'(paddle_en), 0);
    for (int i = 0; i < 9; i++) begin
      frame_tick = i[0];
      hit = !i[0];
      @(negedge clk);
    end
    frame_tick = 0; hit = 0;
    chk("held.state", int'(state), 3);
    chk("held.score", int'(score), 0);
    start = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    chk("resume.state", int'(state), 2);
    start = 0;

    hit = 1;
    repeat (9998) @(negedge clk);
    hit = 0;
    chk("sat.score9998", int'(score), 16'h9998);
    repeat (3) pulse(0, 1, 0, 0);
    chk("sat.score", int'(score), 16'h9999);
    chk("sat.level", int'(level), 3);

    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    repeat (4000) begin
      frame_tick = ($urandom_range(0, 1) == 1);
      hit        = ($urandom_range(0, 3) == 0);
      miss       = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) start = ~start;
      @(negedge clk);
    end
    frame_tick = 0; hit = 0; miss = 0; start = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
